// File: rtl/aes128_iter_core_if.sv
// Handshake bundle for aes128_iter_core: plaintext/key in, ciphertext out.
// master drives in_valid/in/key/out_ready; slave (the core) drives the rest.
interface aes128_iter_core_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in;
    logic [127:0]     key;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     ciphertext;
    logic             busy;
    logic [CNT_W-1:0] blocks_done;

    modport master (
        output in_valid, in, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy, blocks_done
    );

    modport slave (
        input  in_valid, in, key, out_ready,
        output in_ready, out_valid, ciphertext, busy, blocks_done
    );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encrypt core, UNROLL rounds per clock, one block in flight.
// Ports: clk, reset (sync, active-high), bus (slave): handshake in/out + counter.
module aes128_iter_core #(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               reset,
    aes128_iter_core_if.slave bus
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad
        $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i sits at [127-8i -: 8], i = row + 4*col. SubBytes and
    // ShiftRows are both bytewise, so they are fused into one pass.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(w+4*c) -: 8] = SBOX[s[127-8*(w+4*((c+w)%4)) -: 8]];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] aes_round(
        input logic [127:0] s,
        input logic [127:0] k,
        input logic         last
    );
        logic [127:0] t;
        t = sub_shift(s);
        if (!last) begin
            t = {mix_col(t[127:96]), mix_col(t[95:64]),
                 mix_col(t[63:32]), mix_col(t[31:0])};
        end
        return t ^ k;
    endfunction

    function automatic logic [127:0] expand_key(
        input logic [127:0] k,
        input logic [7:0]   rc
    );
        logic [31:0] t, n0, n1, n2, n3;
        t = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]};
        t = t ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           fsm;
    logic [127:0]     st_q;
    logic [127:0]     rk_q;
    logic [3:0]       rnd_q;
    logic [7:0]       rcon_q;
    logic [127:0]     ct_q;
    logic             in_rdy_q;
    logic             ov_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic [127:0]     st_f;
    logic [127:0]     rk_f;
    logic [7:0]       rc_f;
    logic [3:0]       rnd_n;

    // rcon_q always holds rcon for the next round; each cascaded stage
    // expands its own key and hands the advanced rcon to the next stage.
    for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
        logic [127:0] st_i, rk_i, st_o, rk_o;
        logic [7:0]   rc_i, rc_o;
        if (u == 0) begin : g_head
            assign st_i = st_q;
            assign rk_i = rk_q;
            assign rc_i = rcon_q;
        end else begin : g_link
            assign st_i = g_rnd[u-1].st_o;
            assign rk_i = g_rnd[u-1].rk_o;
            assign rc_i = g_rnd[u-1].rc_o;
        end
        assign rk_o = expand_key(rk_i, rc_i);
        assign rc_o = xtime(rc_i);
        assign st_o = aes_round(st_i, rk_o, (rnd_q + 4'(u + 1)) == 4'd10);
    end

    assign st_f  = g_rnd[UNROLL-1].st_o;
    assign rk_f  = g_rnd[UNROLL-1].rk_o;
    assign rc_f  = g_rnd[UNROLL-1].rc_o;
    assign rnd_n = rnd_q + 4'(UNROLL);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm      <= IDLE;
            st_q     <= '0;
            rk_q     <= '0;
            rnd_q    <= '0;
            rcon_q   <= '0;
            ct_q     <= '0;
            in_rdy_q <= 1'b1;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        st_q     <= bus.in ^ bus.key;
                        rk_q     <= bus.key;
                        rnd_q    <= '0;
                        rcon_q   <= 8'h01;
                        in_rdy_q <= 1'b0;
                        busy_q   <= 1'b1;
                        fsm      <= RUN;
                    end
                end
                RUN: begin
                    st_q   <= st_f;
                    rk_q   <= rk_f;
                    rcon_q <= rc_f;
                    rnd_q  <= rnd_n;
                    if (rnd_n == 4'd10) begin
                        ct_q <= st_f;
                        ov_q <= 1'b1;
                        fsm  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ov_q     <= 1'b0;
                        in_rdy_q <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        fsm      <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_rdy_q;
    assign bus.out_valid   = ov_q;
    assign bus.ciphertext  = ct_q;
    assign bus.busy        = busy_q;
    assign bus.blocks_done = cnt_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Scoreboard bench for aes128_iter_core: FIPS vectors, backpressure, reset,
// back-to-back traffic on UNROLL=1, plus UNROLL=2/5/10 and CNT_W=2 instances.
module tb_aes128_iter_core;

    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_g = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   g_fin = 0;
    int   t_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    aes128_iter_core_if #(.CNT_W(16)) m ();
    aes128_iter_core #(.UNROLL(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .bus(m)
    );

    logic [127:0] qm [$];
    logic         ovq_m = 1'b0;

    always @(negedge clk) begin
        if (m.out_valid && !ovq_m) chk("lat", cyc - t_acc, 10);
        ovq_m <= m.out_valid;
        if (m.out_valid && m.out_ready) begin
            if (qm.size() == 0) chk("spurious", 1, 0);
            else chk("ct", m.ciphertext, qm.pop_front());
        end
    end

    task automatic send_m(input logic [127:0] p, input logic [127:0] k,
                          input logic [127:0] c, input bit hold);
        int n = 0;
        while (!m.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) chk("rdy_timeout", 0, 1);
        m.in_valid = 1'b1;
        m.in = p;
        m.key = k;
        @(posedge clk); #1;
        t_acc = cyc;
        qm.push_back(c);
        if (!hold) begin
            // later input changes must not disturb the captured block
            m.in_valid = 1'b0;
            m.in = '1;
            m.key = '1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((qm.size() != 0 || !m.in_ready) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("idle_timeout", 0, 1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, m.in_ready, 1);
        chk({tag, "_out_valid"}, m.out_valid, 0);
        chk({tag, "_busy"}, m.busy, 0);
        chk({tag, "_ct"}, m.ciphertext, 0);
        chk({tag, "_cnt"}, m.blocks_done, 0);
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int U  = (g == 0) ? 2 : (g == 1) ? 5 : 10;
        localparam int CW = (g == 3) ? 2 : 16;
        localparam int NB = (g == 3) ? 5 : 1;

        aes128_iter_core_if #(.CNT_W(CW)) b ();
        aes128_iter_core #(.UNROLL(U), .CNT_W(CW)) dut (
            .clk(clk), .reset(rst_g), .bus(b)
        );

        logic [127:0] q [$];
        int           ta = 0;
        logic         ovq = 1'b0;

        initial begin
            b.in_valid = 1'b0;
            b.in = '0;
            b.key = '0;
            b.out_ready = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            for (int i = 0; i < NB; i++) begin
                int n;
                n = 0;
                while (!b.in_ready && n < 100) begin
                    @(posedge clk); #1; n++;
                end
                if (n >= 100) chk("g_rdy_timeout", 0, 1);
                b.in_valid = 1'b1;
                b.in = P2;
                b.key = K2;
                @(posedge clk); #1;
                ta = cyc;
                q.push_back(C2);
                b.in_valid = 1'b0;
                n = 0;
                while (q.size() != 0 && n < 100) begin
                    @(posedge clk); #1; n++;
                end
                if (n >= 100) chk("g_done_timeout", 0, 1);
            end
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("g%0d_cnt", g), b.blocks_done, NB % (1 << CW));
            g_fin++;
        end

        always @(negedge clk) begin
            if (b.out_valid && !ovq) chk($sformatf("g%0d_lat", g), cyc - ta, 10 / U);
            ovq <= b.out_valid;
            if (b.out_valid && b.out_ready) begin
                if (q.size() == 0) chk("g_spurious", 1, 0);
                else chk($sformatf("g%0d_ct", g), b.ciphertext, q.pop_front());
            end
        end
    end

    initial begin
        rst_g = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_g = 1'b0;
    end

    initial begin
        int n;
        int t_prev;
        reset = 1'b1;
        m.in_valid = 1'b0;
        m.in = '0;
        m.key = '0;
        m.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;

        // FIPS C.1; send_m scrambles in/key right after accept
        send_m(P1, K1, C1, 1'b0);
        wait_idle();
        chk("t1_cnt", m.blocks_done, 1);

        // sink stalls for 20 cycles
        m.out_ready = 1'b0;
        send_m(P1, K1, C1, 1'b0);
        n = 0;
        while (!m.out_valid && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) chk("ov_timeout", 0, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_ov", m.out_valid, 1);
            chk("bp_ct", m.ciphertext, C1);
            chk("bp_in_ready", m.in_ready, 0);
            chk("bp_cnt", m.blocks_done, 1);
        end
        @(posedge clk); #1;
        m.out_ready = 1'b1;
        wait_idle();
        chk("t3_cnt", m.blocks_done, 2);

        // reset mid-run discards the block
        send_m(P1, K1, C1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_busy", m.busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        qm.delete();
        check_reset_state("t5");
        send_m(P1, K1, C1, 1'b0);
        wait_idle();
        chk("t5_cnt", m.blocks_done, 1);

        // back-to-back with in_valid and out_ready held high
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        qm.delete();
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            send_m(P1, K1, C1, 1'b1);
            // one DONE cycle plus one IDLE cycle between runs
            if (i > 0) chk("b2b_gap", t_acc - t_prev, 12);
            t_prev = t_acc;
        end
        m.in_valid = 1'b0;
        wait_idle();
        chk("t6_cnt", m.blocks_done, 4);

        n = 0;
        while (g_fin < 4 && n < 2000) begin
            @(posedge clk); n++;
        end
        if (n >= 2000) chk("cfg_timeout", 0, 1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
